// File: rtl/pipeline_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer,
// flush-to-bubble squashing, tag sideband and saturating stall/bubble counters.
// Main entry M drives the outputs. Skid entry S catches the one beat accepted
// while M is stalled. Invalid entries always hold zero contents, so the outputs
// read as a NOP bubble whenever out_valid is low.
module pipeline_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [CNT_W-1:0]         stall_count,
    output logic [CNT_W-1:0]         bubble_count
);

    localparam int unsigned BUS_W = NUM_CH * DATA_W;

    // Main entry (drives outputs)
    logic             mValid;
    logic [BUS_W-1:0] mData;
    logic [TAG_W-1:0] mTag;

    // Skid entry (overflow while M is stalled)
    logic             sValid;
    logic [BUS_W-1:0] sData;
    logic [TAG_W-1:0] sTag;

    // Next-state values
    logic             mValidNxt;
    logic [BUS_W-1:0] mDataNxt;
    logic [TAG_W-1:0] mTagNxt;
    logic             sValidNxt;
    logic [BUS_W-1:0] sDataNxt;
    logic [TAG_W-1:0] sTagNxt;

    logic accept;
    logic deliver;
    logic stallCond;
    logic bubbleCond;

    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] bubbleCnt;

    // in_ready depends only on the skid flop, never on out_ready
    assign in_ready  = ~sValid;
    assign accept    = in_valid & ~sValid;
    assign deliver   = mValid & out_ready;

    assign out_valid = mValid;
    assign out_data  = mData;
    assign out_tag   = mTag;

    assign stallCond  = mValid & ~out_ready;
    assign bubbleCond = ~mValid & out_ready;

    assign stall_count  = stallCnt;
    assign bubble_count = bubbleCnt;

    // Entry next-state: flush first, then deliver, then accept
    always_comb begin
        mValidNxt = mValid;
        mDataNxt  = mData;
        mTagNxt   = mTag;
        sValidNxt = sValid;
        sDataNxt  = sData;
        sTagNxt   = sTag;

        if (flush) begin
            mValidNxt = 1'b0;
            mDataNxt  = '0;
            mTagNxt   = '0;
            sValidNxt = 1'b0;
            sDataNxt  = '0;
            sTagNxt   = '0;
        end else if (deliver) begin
            if (sValid) begin
                // Skid drains into main; accept cannot coincide (in_ready=0)
                mValidNxt = 1'b1;
                mDataNxt  = sData;
                mTagNxt   = sTag;
                sValidNxt = 1'b0;
                sDataNxt  = '0;
                sTagNxt   = '0;
            end else if (accept) begin
                mValidNxt = 1'b1;
                mDataNxt  = in_data;
                mTagNxt   = in_tag;
            end else begin
                mValidNxt = 1'b0;
                mDataNxt  = '0;
                mTagNxt   = '0;
            end
        end else if (accept) begin
            if (mValid) begin
                sValidNxt = 1'b1;
                sDataNxt  = in_data;
                sTagNxt   = in_tag;
            end else begin
                mValidNxt = 1'b1;
                mDataNxt  = in_data;
                mTagNxt   = in_tag;
            end
        end
    end

    // Entry registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mValid <= 1'b0;
            mData  <= '0;
            mTag   <= '0;
            sValid <= 1'b0;
            sData  <= '0;
            sTag   <= '0;
        end else begin
            mValid <= mValidNxt;
            mData  <= mDataNxt;
            mTag   <= mTagNxt;
            sValid <= sValidNxt;
            sData  <= sDataNxt;
            sTag   <= sTagNxt;
        end
    end

    // Saturating stall counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (stallCond && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    // Saturating bubble counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubbleCnt <= '0;
        end else if (bubbleCond && (bubbleCnt != '1)) begin
            bubbleCnt <= bubbleCnt + CNT_W'(1);
        end
    end

endmodule
